imm_gen_ctrl: RTL and testbench

//  Decode-stage immediate controller. Accepts fetched 16-bit WISC instructions over a

---
 rtl/imm_gen_ctrl_pkg.sv | 50 +++++
 rtl/imm_gen_ctrl_decode.sv | 45 ++++
 rtl/imm_gen_ctrl.sv | 117 +++++++++++
 tb/tb_imm_gen_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_ctrl_pkg.sv
// Shared definitions for the decode-stage immediate controller.
//   - WISC opcode constants (instr[15:11]) for every immediate-bearing instruction
//   - immediate-kind encodings carried alongside each decoded entry
//   - skid-buffer occupancy states
//   - buffer entry record
package imm_gen_ctrl_pkg;

    // Immediate-bearing opcodes
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;
    localparam logic [4:0] OP_BLTZ  = 5'b01110;
    localparam logic [4:0] OP_BGEZ  = 5'b01111;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_STU   = 5'b10011;
    localparam logic [4:0] OP_ROLI  = 5'b10100;
    localparam logic [4:0] OP_SLLI  = 5'b10101;
    localparam logic [4:0] OP_RORI  = 5'b10110;
    localparam logic [4:0] OP_SRLI  = 5'b10111;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_JR    = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_JALR  = 5'b00111;

    // Immediate kinds
    localparam logic [1:0] KIND_NONE = 2'd0;
    localparam logic [1:0] KIND_I5   = 2'd1;
    localparam logic [1:0] KIND_I8   = 2'd2;
    localparam logic [1:0] KIND_D11  = 2'd3;

    // Skid-buffer occupancy
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] imm;
        logic [1:0]  kind;
    } entry_t;

endpackage

// File: rtl/imm_gen_ctrl_decode.sv
// imm_decode: combinational opcode -> immediate / kind decoder.
// Ports:
//   instr  in  16  instruction; opcode = instr[15:11]
//   imm    out 16  extended immediate (0 for non-immediate opcodes)
//   kind   out 2   KIND_NONE / KIND_I5 / KIND_I8 / KIND_D11
module imm_decode
    import imm_gen_ctrl_pkg::*;
(
    input  logic [15:0] instr,
    output logic [15:0] imm,
    output logic [1:0]  kind
);

    always_comb begin
        imm  = '0;
        kind = KIND_NONE;
        case (instr[15:11])
            OP_ADDI, OP_SUBI, OP_ST, OP_LD, OP_STU: begin
                imm  = {{11{instr[4]}}, instr[4:0]};
                kind = KIND_I5;
            end
            OP_XORI, OP_ANDNI, OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
                imm  = {11'b0, instr[4:0]};
                kind = KIND_I5;
            end
            OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ, OP_LBI, OP_JR, OP_JALR: begin
                imm  = {{8{instr[7]}}, instr[7:0]};
                kind = KIND_I8;
            end
            OP_SLBI: begin
                imm  = {8'b0, instr[7:0]};
                kind = KIND_I8;
            end
            OP_J, OP_JAL: begin
                imm  = {{5{instr[10]}}, instr[10:0]};
                kind = KIND_D11;
            end
            default: begin
                imm  = '0;
                kind = KIND_NONE;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_ctrl.sv
// imm_gen_ctrl: decode-stage immediate controller with a 2-entry skid buffer.
// Instructions are decoded at push and stored with their immediate; the head entry
// drives out_* directly from registers.
// Optional feature macro: IMM_STATS_EN adds parameter CNT_W and a saturating
// imm_count of popped entries whose kind is not KIND_NONE (cleared by reset only).
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready/in_instr  fetch-side handshake
//   flush                       drop all buffered entries
//   out_valid/out_ready         execute-side handshake
//   out_imm/out_kind/out_instr  head entry contents
//   imm_count                   issued-immediate count (IMM_STATS_EN only)
module imm_gen_ctrl
    import imm_gen_ctrl_pkg::*;
`ifdef IMM_STATS_EN
#(
    parameter int unsigned CNT_W = 16
)
`endif
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_imm,
    output logic [1:0]       out_kind,
    output logic [15:0]      out_instr
`ifdef IMM_STATS_EN
    ,
    output logic [CNT_W-1:0] imm_count
`endif
);

    buf_state_e  state_q;
    entry_t      head_q;
    entry_t      tail_q;
    entry_t      in_entry;
    logic [15:0] dec_imm;
    logic [1:0]  dec_kind;
    logic        push;
    logic        pop;

    imm_decode u_decode (
        .instr (in_instr),
        .imm   (dec_imm),
        .kind  (dec_kind)
    );

    assign in_entry  = '{instr: in_instr, imm: dec_imm, kind: dec_kind};

    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_imm   = head_q.imm;
    assign out_kind  = head_q.kind;
    assign out_instr = head_q.instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else if (flush) begin
            // Entry payloads are left as-is; only occupancy is cleared.
            state_q <= ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        head_q  <= in_entry;
                        state_q <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head_q <= in_entry;
                    end else if (push) begin
                        tail_q  <= in_entry;
                        state_q <= ST_TWO;
                    end else if (pop) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        head_q  <= tail_q;
                        state_q <= ST_ONE;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

`ifdef IMM_STATS_EN
    logic [CNT_W-1:0] count_q;

    // A pop coincident with flush was still consumed by execute, so it counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (pop && (head_q.kind != KIND_NONE) && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign imm_count = count_q;
`endif

endmodule

// File: tb/tb_imm_gen_ctrl.sv
module tb_imm_gen_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm;
    logic [1:0]  out_kind;
    logic [15:0] out_instr;
`ifdef IMM_STATS_EN
    logic [3:0]  imm_count;
`endif

    int n_vec;
    int n_err;

`ifdef IMM_STATS_EN
    imm_gen_ctrl #(
        .CNT_W (4)
    ) dut (
`else
    imm_gen_ctrl dut (
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_kind  (out_kind),
        .out_instr (out_instr)
`ifdef IMM_STATS_EN
        ,
        .imm_count (imm_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
        #12;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_vec++; if ({out_imm, out_kind, out_instr} !== 34'h0) begin
            n_err++; $display("FAIL reset_outputs: got imm=%h kind=%0d instr=%h want all 0", out_imm, out_kind, out_instr);
        end
`ifdef IMM_STATS_EN
        n_vec++; if (imm_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", imm_count); end
`endif
        #1 rst_n = 1'b1;
        cycle();
    endtask

    // Stream directed vectors at full rate; each appears on out_* one cycle after push.
    task automatic test_decode();
        logic [15:0] vi [12] = '{16'h4010, 16'h501F, 16'hC080, 16'h9080, 16'h2400, 16'h0000,
                                 16'h87FF, 16'h92FF, 16'h33FF, 16'h581F, 16'hFFFF, 16'h6C7F};
        logic [15:0] ve [12] = '{16'hFFF0, 16'h001F, 16'hFF80, 16'h0080, 16'hFC00, 16'h0000,
                                 16'hFFFF, 16'h00FF, 16'h03FF, 16'h001F, 16'h0000, 16'h007F};
        logic [1:0]  vk [12] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0,
                                 2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd2};
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_instr = vi[i];
            cycle();
            n_vec++;
            if (out_valid !== 1'b1 || out_imm !== ve[i] || out_kind !== vk[i] || out_instr !== vi[i]) begin
                n_err++;
                $display("FAIL decode[%0d] instr=%h: got v=%b imm=%h kind=%0d instr=%h want v=1 imm=%h kind=%0d",
                         i, vi[i], out_valid, out_imm, out_kind, out_instr, ve[i], vk[i]);
            end
        end
        in_valid = 1'b0;
        cycle();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL decode_drain: got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h4001;
        cycle();
        in_instr = 16'h4002;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_one: got %b want 1", in_ready); end
        cycle();
        in_instr = 16'h4003;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_full: got %b want 0", in_ready); end
        cycle();
        n_vec++; if (in_ready !== 1'b0 || out_instr !== 16'h4001 || out_imm !== 16'h0001) begin
            n_err++; $display("FAIL b2b_hold: got rdy=%b instr=%h imm=%h want 0/4001/0001", in_ready, out_instr, out_imm);
        end
        out_ready = 1'b1;
        cycle();
        n_vec++; if (out_instr !== 16'h4002 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_second: got instr=%h rdy=%b want 4002/1", out_instr, in_ready);
        end
        cycle();
        in_valid = 1'b0;
        n_vec++; if (out_instr !== 16'h4003 || out_imm !== 16'h0003 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL b2b_third: got instr=%h imm=%h v=%b want 4003/0003/1", out_instr, out_imm, out_valid);
        end
        cycle();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h4001;
        cycle();
        in_instr = 16'h4002;
        cycle();
        in_instr = 16'h4003;
        flush    = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL flush_two: got v=%b rdy=%b want 0/1", out_valid, in_ready);
        end
        cycle();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_two_lost: got v=%b want 0", out_valid); end
        // Flush in ONE with simultaneous push and pop: the push must be dropped.
        in_valid = 1'b1;
        in_instr = 16'h4004;
        cycle();
        in_instr  = 16'h4005;
        out_ready = 1'b1;
        flush     = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_one_push: got v=%b want 0", out_valid); end
        in_valid = 1'b1;
        in_instr = 16'h4006;
        cycle();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || out_instr !== 16'h4006) begin
            n_err++; $display("FAIL flush_resume: got v=%b instr=%h want 1/4006", out_valid, out_instr);
        end
        cycle();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h4001;
        cycle();
        in_instr = 16'h4002;
        cycle();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 16'h0000) begin
            n_err++; $display("FAIL rst_mid: got v=%b rdy=%b instr=%h want 0/1/0000", out_valid, in_ready, out_instr);
        end
        #1 rst_n = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 16'hC080;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || out_imm !== 16'hFF80 || out_kind !== 2'd2 || out_instr !== 16'hC080) begin
            n_err++; $display("FAIL rst_resume: got v=%b imm=%h kind=%0d instr=%h want 1/FF80/2/C080",
                              out_valid, out_imm, out_kind, out_instr);
        end
        cycle();
    endtask

`ifdef IMM_STATS_EN
    task automatic push_n(input logic [15:0] instr, input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_instr = instr;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic test_stats();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        cycle();
        push_n(16'h0000, 3);
        n_vec++; if (imm_count !== 4'd0) begin n_err++; $display("FAIL stats_none: got %0d want 0", imm_count); end
        push_n(16'h4010, 14);
        n_vec++; if (imm_count !== 4'd14) begin n_err++; $display("FAIL stats_14: got %0d want 14", imm_count); end
        push_n(16'hC080, 1);
        n_vec++; if (imm_count !== 4'd15) begin n_err++; $display("FAIL stats_15: got %0d want 15", imm_count); end
        push_n(16'h2400, 5);
        n_vec++; if (imm_count !== 4'd15) begin n_err++; $display("FAIL stats_sat: got %0d want 15", imm_count); end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        n_vec++; if (imm_count !== 4'd15) begin n_err++; $display("FAIL stats_flush: got %0d want 15", imm_count); end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_reset_mid();
`ifdef IMM_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
